// File: rtl/broadsync_pkg.sv
// Shared types and constants for the BroadSync time-code receiver.
package broadsync_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HUNT,
    ST_LOCK,
    ST_PAYLOAD,
    ST_CRC,
    ST_TRAIL
  } state_t;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_START   = 3'd1;
  localparam logic [2:0] ERR_HB_DROP = 3'd2;
  localparam logic [2:0] ERR_CRC     = 3'd3;
  localparam logic [2:0] ERR_TRAIL   = 3'd4;
  localparam logic [2:0] ERR_WDOG    = 3'd5;

  localparam logic [7:0] CRC8_POLY = 8'h31;
  localparam logic [7:0] CRC8_SEED = 8'hFF;

  // One serial step of the x^8+x^5+x^4+1 CRC, MSB-feedback form.
  function automatic logic [7:0] crc8_next(input logic [7:0] q, input logic d);
    logic fb;
    fb = q[7] ^ d;
    return {q[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/broadsync_crc8.sv
// Serial CRC-8 accumulator: init reseeds, en folds in one data bit.
module broadsync_crc8
  import broadsync_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init,
  input  logic       en,
  input  logic       d,
  output logic [7:0] crc
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc <= 8'h00;
    end else if (init) begin
      crc <= CRC8_SEED;
    end else if (en) begin
      crc <= crc8_next(crc, d);
    end
  end

endmodule

// File: rtl/broadsync_rx.sv
// BroadSync slave receiver: synchronises the three pins, deframes, checks CRC-8,
// publishes lock/time/accuracy on a good frame and classifies every rejection.
module broadsync_rx
  import broadsync_pkg::*;
#(
  parameter int TIME_W        = 80,
  parameter int ACC_W         = 8,
  parameter int SYNC_STAGES   = 3,
  parameter int START_TIMEOUT = 64,
  parameter int TRAIL_TIMEOUT = 64,
  parameter int WDOG_CYCLES   = 4096,
  parameter int CNT_W         = 16
) (
  input  logic              ptp_clk,
  input  logic              ptp_reset_n,
  input  logic              bitclock_in,
  input  logic              heartbeat_in,
  input  logic              timecode_in,
  output logic              lock_value,
  output logic [TIME_W-1:0] time_value,
  output logic [ACC_W-1:0]  clk_accuracy,
  output logic              frame_valid,
  output logic              frame_error,
  output logic [2:0]        err_code,
  output logic [CNT_W-1:0]  frames_ok,
  output logic [CNT_W-1:0]  frames_err
);

  localparam int P_W  = ACC_W + TIME_W;
  localparam int T_MX = (START_TIMEOUT > TRAIL_TIMEOUT) ? START_TIMEOUT : TRAIL_TIMEOUT;
  localparam int CMAX = (P_W > T_MX) ? P_W : T_MX;
  localparam int BC_W = $clog2(CMAX + 1);
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [SYNC_STAGES-1:0] r_bclk_sync, r_hb_sync, r_tc_sync;
  logic                   r_bclk_d, r_hb_d;
  logic [SYNC_STAGES:0]   r_fill;
  logic                   r_armed;
  state_t                 r_state, w_state_nx;
  logic [BC_W-1:0]        r_cnt, w_cnt_nx;
  logic [WD_W-1:0]        r_wdog, w_wdog_nx;
  logic [P_W-1:0]         r_pay;
  logic [7:0]             r_rx_crc;
  logic                   r_lock_rx;
  logic [7:0]             w_crc;
  logic w_bclk_s, w_hb_s, w_tc_s, w_edge, w_hb_rise, w_hb_fall, w_armed;
  logic w_hb_drop, w_wdog_exp, w_err, w_commit;
  logic w_crc_init, w_crc_en, w_pay_sh, w_rxcrc_sh, w_lock_ld;
  logic [2:0] w_err_code;

  // Pin synchronisers; r_fill marks when *_d reflects real pin values after reset.
  always_ff @(posedge ptp_clk) begin
    if (!ptp_reset_n) begin
      r_bclk_sync <= '0;
      r_hb_sync   <= '0;
      r_tc_sync   <= '0;
      r_bclk_d    <= 1'b0;
      r_hb_d      <= 1'b0;
      r_fill      <= '0;
      r_armed     <= 1'b0;
    end else begin
      r_bclk_sync <= {r_bclk_sync[SYNC_STAGES-2:0], bitclock_in};
      r_hb_sync   <= {r_hb_sync[SYNC_STAGES-2:0], heartbeat_in};
      r_tc_sync   <= {r_tc_sync[SYNC_STAGES-2:0], timecode_in};
      r_bclk_d    <= w_bclk_s;
      r_hb_d      <= w_hb_s;
      r_fill      <= {r_fill[SYNC_STAGES-1:0], 1'b1};
      r_armed     <= w_armed;
    end
  end

  assign w_bclk_s  = r_bclk_sync[SYNC_STAGES-1];
  assign w_hb_s    = r_hb_sync[SYNC_STAGES-1];
  assign w_tc_s    = r_tc_sync[SYNC_STAGES-1];
  assign w_edge    = w_bclk_s & ~r_bclk_d;
  assign w_hb_rise = w_hb_s & ~r_hb_d;
  assign w_hb_fall = ~w_hb_s & r_hb_d;
  // A heartbeat already high out of reset must go low before a rise counts.
  assign w_armed   = r_armed | (r_fill[SYNC_STAGES] & ~r_hb_d);

  assign w_hb_drop  = ~w_hb_s & ((r_state == ST_HUNT) || (r_state == ST_LOCK) ||
                                 (r_state == ST_PAYLOAD) || (r_state == ST_CRC));
  assign w_wdog_exp = (r_state != ST_IDLE) && !w_edge && (r_wdog == WD_W'(WDOG_CYCLES - 1));

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_err      = 1'b0;
    w_err_code = ERR_NONE;
    w_commit   = 1'b0;
    w_crc_init = 1'b0;
    w_crc_en   = 1'b0;
    w_pay_sh   = 1'b0;
    w_rxcrc_sh = 1'b0;
    w_lock_ld  = 1'b0;
    w_wdog_nx  = (r_state == ST_IDLE || w_edge) ? '0 : r_wdog + 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_crc_init = 1'b1;
        w_cnt_nx   = '0;
        if (w_hb_rise && w_armed) w_state_nx = ST_HUNT;
      end
      ST_HUNT: if (w_edge) begin
        if (w_tc_s) begin
          w_state_nx = ST_LOCK;
          w_cnt_nx   = '0;
        end else if (r_cnt == BC_W'(START_TIMEOUT - 1)) begin
          w_err      = 1'b1;
          w_err_code = ERR_START;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      ST_LOCK: if (w_edge) begin
        w_lock_ld  = 1'b1;
        w_state_nx = ST_PAYLOAD;
        w_cnt_nx   = '0;
      end
      ST_PAYLOAD: if (w_edge) begin
        w_pay_sh = 1'b1;
        w_crc_en = 1'b1;
        if (r_cnt == BC_W'(P_W - 1)) begin
          w_state_nx = ST_CRC;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      ST_CRC: if (w_edge) begin
        w_rxcrc_sh = 1'b1;
        if (r_cnt == BC_W'(7)) begin
          w_state_nx = ST_TRAIL;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      ST_TRAIL: begin
        if (w_hb_fall) begin
          w_state_nx = ST_IDLE;
          if (r_rx_crc == w_crc) begin
            w_commit = 1'b1;
          end else begin
            w_err      = 1'b1;
            w_err_code = ERR_CRC;
          end
        end else if (w_edge) begin
          if (r_cnt == BC_W'(TRAIL_TIMEOUT - 1)) begin
            w_err      = 1'b1;
            w_err_code = ERR_TRAIL;
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
    if (w_hb_drop) begin
      w_err      = 1'b1;
      w_err_code = ERR_HB_DROP;
    end else if (w_wdog_exp && !w_err && !w_commit) begin
      w_err      = 1'b1;
      w_err_code = ERR_WDOG;
    end
    if (w_err) w_state_nx = ST_IDLE;
  end

  broadsync_crc8 u_crc (
    .clk   (ptp_clk),
    .rst_n (ptp_reset_n),
    .init  (w_crc_init),
    .en    (w_crc_en),
    .d     (w_tc_s),
    .crc   (w_crc)
  );

  // Frame data shifters: payload and received CRC both arrive LSB first.
  always_ff @(posedge ptp_clk) begin
    if (w_pay_sh)   r_pay     <= {w_tc_s, r_pay[P_W-1:1]};
    if (w_rxcrc_sh) r_rx_crc  <= {w_tc_s, r_rx_crc[7:1]};
    if (w_lock_ld)  r_lock_rx <= w_tc_s;
  end

  always_ff @(posedge ptp_clk) begin
    if (!ptp_reset_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_wdog       <= '0;
      lock_value   <= 1'b0;
      time_value   <= '0;
      clk_accuracy <= '0;
      frame_valid  <= 1'b0;
      frame_error  <= 1'b0;
      err_code     <= ERR_NONE;
      frames_ok    <= '0;
      frames_err   <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_wdog      <= w_wdog_nx;
      frame_valid <= w_commit;
      frame_error <= w_err;
      if (w_err) begin
        err_code   <= w_err_code;
        frames_err <= sat_inc(frames_err);
      end
      if (w_commit) begin
        lock_value   <= r_lock_rx;
        time_value   <= r_pay[P_W-1:ACC_W];
        clk_accuracy <= r_pay[ACC_W-1:0];
        frames_ok    <= sat_inc(frames_ok);
      end
    end
  end

endmodule

// File: tb/tb_broadsync_rx.sv
// Directed bench for broadsync_rx: vector table of whole frames plus hand sequences
// for timeouts, heartbeat drop, reset mid-frame and counter saturation.
module tb_broadsync_rx;

  localparam int PH   = 5;
  localparam int SYNC = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] bclk, hb, tc;
  logic [2:0] fv, fe, lk;
  logic [2:0] ec0, ec1, ec2;
  logic [79:0] t0, t1;
  logic [63:0] t2;
  logic [7:0]  a0, a1;
  logic [15:0] a2;
  logic [15:0] ok0, er0;
  logic [1:0]  ok1, er1, ok2, er2;

  always #5 clk = ~clk;

  broadsync_rx dut0 (
    .ptp_clk(clk), .ptp_reset_n(rst_n), .bitclock_in(bclk[0]), .heartbeat_in(hb[0]),
    .timecode_in(tc[0]), .lock_value(lk[0]), .time_value(t0), .clk_accuracy(a0),
    .frame_valid(fv[0]), .frame_error(fe[0]), .err_code(ec0), .frames_ok(ok0), .frames_err(er0)
  );

  broadsync_rx #(.CNT_W(2)) dut1 (
    .ptp_clk(clk), .ptp_reset_n(rst_n), .bitclock_in(bclk[1]), .heartbeat_in(hb[1]),
    .timecode_in(tc[1]), .lock_value(lk[1]), .time_value(t1), .clk_accuracy(a1),
    .frame_valid(fv[1]), .frame_error(fe[1]), .err_code(ec1), .frames_ok(ok1), .frames_err(er1)
  );

  broadsync_rx #(.TIME_W(64), .ACC_W(16), .CNT_W(2)) dut2 (
    .ptp_clk(clk), .ptp_reset_n(rst_n), .bitclock_in(bclk[2]), .heartbeat_in(hb[2]),
    .timecode_in(tc[2]), .lock_value(lk[2]), .time_value(t2), .clk_accuracy(a2),
    .frame_valid(fv[2]), .frame_error(fe[2]), .err_code(ec2), .frames_ok(ok2), .frames_err(er2)
  );

  int total = 0;
  int bad = 0;
  int nv [3] = '{0, 0, 0};
  int ne [3] = '{0, 0, 0};
  int nboth = 0;
  int last_lat;
  int mid_ne;

  logic        e_lock;
  logic [79:0] e_time;
  logic [7:0]  e_acc;
  logic [2:0]  e_code;
  int          e_ok, e_err;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (fv[i]) nv[i]++;
      if (fe[i]) ne[i]++;
      if (fv[i] && fe[i]) nboth++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_dut0(input string tag);
    chk({tag, "_code"}, ec0, e_code);
    chk({tag, "_lock"}, lk[0], e_lock);
    chk({tag, "_time"}, t0, e_time);
    chk({tag, "_acc"}, a0, e_acc);
    chk({tag, "_ok"}, ok0, e_ok);
    chk({tag, "_err"}, er0, e_err);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference CRC written straight from the per-bit next-state equations.
  function automatic logic [7:0] crc_model(input logic [127:0] pay, input int n);
    logic [7:0] q;
    logic f;
    q = 8'hFF;
    for (int i = 0; i < n; i++) begin
      f = q[7] ^ pay[i];
      q = {q[6], q[5], q[4] ^ f, q[3] ^ f, q[2], q[1], q[0], f};
    end
    return q;
  endfunction

  task automatic send_bit(input int sel, input logic b);
    tc[sel]   = b;
    bclk[sel] = 1'b0;
    repeat (PH) tick();
    bclk[sel] = 1'b1;
    repeat (PH) tick();
  endtask

  task automatic measure(input int sel);
    last_lat = -1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (last_lat < 0 && (fv[sel] || fe[sel])) last_lat = k;
    end
  endtask

  // cut_kind: 1 drop heartbeat, 2 stop bit clock, 3 pulse reset, at payload bit cut_at.
  task automatic send_frame(input int sel, input logic lock, input logic [127:0] pay,
                            input int plen, input logic [7:0] cxor, input int cut_at,
                            input int cut_kind, input int trail_n);
    logic [7:0] c;
    c = crc_model(pay, plen) ^ cxor;
    hb[sel] = 1'b1;
    repeat (8) tick();
    send_bit(sel, 1'b0);
    send_bit(sel, 1'b0);
    send_bit(sel, 1'b1);
    send_bit(sel, lock);
    for (int i = 0; i < plen; i++) begin
      if (i == cut_at) begin
        if (cut_kind == 1) begin
          hb[sel] = 1'b0;
          measure(sel);
          return;
        end else if (cut_kind == 2) begin
          repeat (4000) tick();
          mid_ne = ne[sel];
          repeat (300) tick();
          return;
        end else begin
          rst_n = 1'b0;
          repeat (3) tick();
          rst_n = 1'b1;
        end
      end
      send_bit(sel, pay[i]);
    end
    for (int j = 0; j < 8; j++) send_bit(sel, c[j]);
    for (int j = 0; j < trail_n; j++) send_bit(sel, 1'b0);
    hb[sel] = 1'b0;
    measure(sel);
  endtask

  typedef struct {
    logic        lock;
    logic [79:0] tim;
    logic [7:0]  acc;
    logic [7:0]  cxor;
    logic        exp_fv;
    logic [2:0]  exp_code;
  } vec_t;

  vec_t vt [5];

  initial begin
    int v, e, xk;
    logic [127:0] pay;
    logic [79:0]  lt1;
    logic [7:0]   la1;
    logic [63:0]  lt2;
    logic [15:0]  la2;
    logic         ll1, ll2;

    vt[0] = '{1'b1, 80'h0000_0000_1234_3B9A_C9FF, 8'h21, 8'h00, 1'b1, 3'd0};
    vt[1] = '{1'b1, 80'h0000_0000_1234_3B9A_C9FF, 8'h21, 8'h08, 1'b0, 3'd3};
    vt[2] = '{1'b0, 80'h0000_0000_0001_0000_0000, 8'h00, 8'h00, 1'b1, 3'd3};
    vt[3] = '{1'b1, 80'hFFFF_FFFF_FFFF_FFFF_FFFF, 8'hFF, 8'h00, 1'b1, 3'd3};
    vt[4] = '{1'b0, 80'h5555_AAAA_0F0F_F0F0_1357, 8'hA5, 8'h80, 1'b0, 3'd3};

    rst_n = 1'b0;
    bclk  = 3'b111;
    hb    = 3'b000;
    tc    = 3'b000;
    e_lock = 1'b0; e_time = '0; e_acc = '0; e_code = 3'd0; e_ok = 0; e_err = 0;
    repeat (5) tick();
    chk_dut0("reset");
    chk("reset_pulses", {fv, fe}, 6'd0);
    chk("reset_ok1", ok1, 2'd0);
    chk("reset_ok2", ok2, 2'd0);
    rst_n = 1'b1;
    repeat (10) tick();

    for (int i = 0; i < 5; i++) begin
      v = nv[0];
      e = ne[0];
      send_frame(0, vt[i].lock, {40'b0, vt[i].tim, vt[i].acc}, 88, vt[i].cxor, -1, 0, 2);
      if (vt[i].exp_fv) begin
        e_lock = vt[i].lock; e_time = vt[i].tim; e_acc = vt[i].acc; e_ok++;
      end else begin
        e_err++;
      end
      e_code = vt[i].exp_code;
      chk("vec_lat", last_lat, SYNC + 1);
      chk("vec_fv_pulses", nv[0] - v, vt[i].exp_fv);
      chk("vec_fe_pulses", ne[0] - e, !vt[i].exp_fv);
      chk_dut0("vec");
    end

    // Heartbeat drop at payload bit 40, then a good frame.
    e = ne[0];
    send_frame(0, 1'b1, {40'b0, 80'hABCD_0123_4567_89AB_CDEF, 8'h77}, 88, 8'h00, 40, 1, 2);
    e_err++; e_code = 3'd2;
    chk("hbdrop_in_window", (last_lat >= 1 && last_lat <= SYNC + 2), 1'b1);
    chk("hbdrop_pulses", ne[0] - e, 1);
    chk("hbdrop_idle", dut0.r_state, 3'd0);
    chk_dut0("hbdrop");
    send_frame(0, 1'b0, {40'b0, 80'h1111_2222_3333_4444_5555, 8'h3C}, 88, 8'h00, -1, 0, 2);
    e_lock = 1'b0; e_time = 80'h1111_2222_3333_4444_5555; e_acc = 8'h3C; e_ok++;
    chk("after_drop_lat", last_lat, SYNC + 1);
    chk_dut0("after_drop");

    // Start-bit timeout: 63 zero edges are tolerated, the 64th is not.
    e = ne[0];
    hb[0] = 1'b1;
    repeat (8) tick();
    for (int i = 0; i < 63; i++) send_bit(0, 1'b0);
    chk("start_63_edges", ne[0] - e, 0);
    send_bit(0, 1'b0);
    chk("start_64_edges", ne[0] - e, 1);
    e_err++; e_code = 3'd1;
    chk_dut0("start_to");
    hb[0] = 1'b0;
    repeat (12) tick();

    // Bit clock stops mid-payload.
    e = ne[0];
    v = nv[0];
    send_frame(0, 1'b1, {40'b0, 80'h0F0F_0F0F_0F0F_0F0F_0F0F, 8'h11}, 88, 8'h00, 20, 2, 2);
    chk("wdog_not_early", mid_ne - e, 0);
    chk("wdog_fired", ne[0] - e, 1);
    e_err++; e_code = 3'd5;
    chk_dut0("wdog");
    hb[0] = 1'b0;
    repeat (12) tick();
    chk("wdog_no_valid", nv[0] - v, 0);

    // Trailer of 63 edges still commits; 64 edges is a timeout.
    send_frame(0, 1'b1, {40'b0, 80'h0000_0000_0000_0000_0001, 8'h80}, 88, 8'h00, -1, 0, 63);
    e_lock = 1'b1; e_time = 80'h1; e_acc = 8'h80; e_ok++;
    chk("trail63_lat", last_lat, SYNC + 1);
    chk_dut0("trail63");
    e = ne[0];
    v = nv[0];
    send_frame(0, 1'b0, {40'b0, 80'h7777_6666_5555_4444_3333, 8'h22}, 88, 8'h00, -1, 0, 64);
    e_err++; e_code = 3'd4;
    chk("trail64_no_commit", nv[0] - v, 0);
    chk("trail64_pulses", ne[0] - e, 1);
    chk_dut0("trail64");

    // Reset in the middle of a payload; the remainder of that frame is ignored.
    e = ne[0];
    v = nv[0];
    send_frame(0, 1'b1, {40'b0, 80'h2222_2222_2222_2222_2222, 8'h44}, 88, 8'h00, 30, 3, 2);
    e_lock = 1'b0; e_time = '0; e_acc = '0; e_code = 3'd0; e_ok = 0; e_err = 0;
    chk("rst_no_pulse_lat", last_lat, -1);
    chk("rst_no_valid", nv[0] - v, 0);
    chk("rst_no_error", ne[0] - e, 0);
    chk_dut0("rst");
    send_frame(0, 1'b1, {40'b0, 80'h0000_0000_1234_3B9A_C9FF, 8'h21}, 88, 8'h00, -1, 0, 2);
    e_lock = 1'b1; e_time = 80'h0000_0000_1234_3B9A_C9FF; e_acc = 8'h21; e_ok = 1;
    chk("post_rst_lat", last_lat, SYNC + 1);
    chk_dut0("post_rst");

    // Two-bit counters saturate at 3, default widths.
    for (int k = 1; k <= 5; k++) begin
      lt1 = {16'hBEEF, 32'(k), 32'hCAFE_0000 + 32'(k)};
      la1 = 8'(k * 3);
      ll1 = k[0];
      send_frame(1, ll1, {40'b0, lt1, la1}, 88, 8'h00, -1, 0, 2);
      xk = (k > 3) ? 3 : k;
      chk("sat1_lat", last_lat, SYNC + 1);
      chk("sat1_ok", ok1, xk);
    end
    chk("sat1_time", t1, lt1);
    chk("sat1_acc", a1, la1);
    chk("sat1_lock", lk[1], ll1);
    chk("sat1_err", {er1, ec1}, 5'd0);

    // Same with a 64-bit time and 16-bit accuracy field.
    for (int k = 1; k <= 5; k++) begin
      lt2 = {32'(k), 32'h0F1E_2D3C};
      la2 = 16'h8000 | 16'(k);
      ll2 = ~k[0];
      send_frame(2, ll2, {48'b0, lt2, la2}, 80, 8'h00, -1, 0, 2);
      xk = (k > 3) ? 3 : k;
      chk("sat2_lat", last_lat, SYNC + 1);
      chk("sat2_ok", ok2, xk);
    end
    chk("sat2_time", t2, lt2);
    chk("sat2_acc", a2, la2);
    chk("sat2_lock", lk[2], ll2);
    chk("sat2_err", {er2, ec2}, 5'd0);

    chk("valid_error_overlap", nboth, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
